// File: rtl/sad_pkg.sv
// Shared widths, engine latency and controller states for the SAD motion-search slice.
`timescale 1ns/1ps
package sad_pkg;

    localparam int DATA_BITS  = 8;
    localparam int BLK_W      = 16 * 16 * DATA_BITS;
    localparam int SAD_W      = 2 * DATA_BITS;
    localparam int ENGINE_LAT = 6;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/sad_min_tracker.sv
// Collects in-order SAD results, numbering them and keeping the strict minimum.
`timescale 1ns/1ps
module sad_min_tracker #(
    parameter int DATA_BITS = 8,
    parameter int CAND_BITS = 6
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   init,
    input  logic [2*DATA_BITS-1:0] sad,
    input  logic                   sad_vld,
    output logic [CAND_BITS-1:0]   rcv_cnt,
    output logic [2*DATA_BITS-1:0] best_sad,
    output logic [CAND_BITS-1:0]   best_idx
);

    // Strict less-than keeps the earliest index on ties.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rcv_cnt  <= '0;
            best_sad <= '0;
            best_idx <= '0;
        end else if (init) begin
            rcv_cnt  <= '0;
            best_sad <= '1;
            best_idx <= '0;
        end else if (sad_vld) begin
            if (sad < best_sad) begin
                best_sad <= sad;
                best_idx <= rcv_cnt;
            end
            rcv_cnt <= rcv_cnt + CAND_BITS'(1);
        end
    end

endmodule

// File: rtl/sad_search_ctrl.sv
// Motion-search controller: fetches candidates, issues them to the SAD engine, reports the minimum.
// Optional early exit on a zero SAD is enabled by defining SAD_ZERO_EXIT_EN.
`timescale 1ns/1ps
module sad_search_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int CAND_BITS = 6
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [CAND_BITS-1:0]         cand_num,
    input  logic [16*16*DATA_BITS-1:0]   cur_blk,
    output logic                         busy,
    output logic                         ref_req,
    output logic [CAND_BITS-1:0]         ref_idx,
    input  logic                         ref_vld,
    input  logic [16*16*DATA_BITS-1:0]   ref_blk,
    output logic [16*16*DATA_BITS-1:0]   din,
    output logic [16*16*DATA_BITS-1:0]   refi,
    output logic                         cal_en,
    input  logic [2*DATA_BITS-1:0]       sad,
    input  logic                         sad_vld,
    output logic [2*DATA_BITS-1:0]       best_sad,
    output logic [CAND_BITS-1:0]         best_idx,
    output logic                         done
);

    import sad_pkg::*;

    state_t               state;
    state_t               state_nxt;
    logic [CAND_BITS-1:0] cand_q;
    logic [CAND_BITS-1:0] issue_cnt;
    logic [CAND_BITS-1:0] rcv_cnt;
    logic                 start_acc;
    logic                 issue;
    logic                 last_issue;
    logic                 zero_hit;

    assign start_acc  = (state == IDLE) && start;
    assign issue      = (state == FETCH) && ref_vld;
    assign last_issue = issue && (issue_cnt == cand_q - CAND_BITS'(1));

`ifdef SAD_ZERO_EXIT_EN
    assign zero_hit = (state == FETCH) && sad_vld && (sad == '0);
`else
    assign zero_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A zero-candidate search spends its one busy cycle in DRAIN, where the
    // counters already match, so done lands two cycles after start.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (cand_num == '0) ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                if (last_issue || zero_hit) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (rcv_cnt == issue_cnt) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            din       <= '0;
            refi      <= '0;
            cal_en    <= 1'b0;
            cand_q    <= '0;
            issue_cnt <= '0;
        end else begin
            cal_en <= issue;
            if (start_acc) begin
                din       <= cur_blk;
                cand_q    <= cand_num;
                issue_cnt <= '0;
            end
            if (issue) begin
                refi      <= ref_blk;
                issue_cnt <= issue_cnt + CAND_BITS'(1);
            end
        end
    end

    assign busy    = (state == FETCH) || (state == DRAIN);
    assign ref_req = (state == FETCH);
    assign ref_idx = issue_cnt;
    assign done    = (state == DONE);

    sad_min_tracker #(
        .DATA_BITS (DATA_BITS),
        .CAND_BITS (CAND_BITS)
    ) u_tracker (
        .clk      (clk),
        .rstn     (rstn),
        .init     (start_acc),
        .sad      (sad),
        .sad_vld  (sad_vld && (state != IDLE)),
        .rcv_cnt  (rcv_cnt),
        .best_sad (best_sad),
        .best_idx (best_idx)
    );

endmodule
